// File: rtl/matrix_scan_ctrl.sv
// Scan sequencer and column-RAM arbiter for the LED-matrix colour path.
// Steps the pixel select through 0..NUM_PIX-1, holding each pixel for DWELL
// clocks. Ant-update write windows are granted only at frame boundaries or
// while the display is idle, so a frame never shows a half-updated board.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   en           display enable
//   upd_req      updater requests a column-RAM write window (level)
//   upd_done     one-cycle pulse from updater: writes finished
//   sel          pixel select to the colour mux
//   pix_valid    sel/colour valid for the matrix driver
//   frame_start  one-cycle pulse on the first cycle of each frame
//   upd_gnt      write window granted; scan halted
//   upd_err      sticky grant-timeout flag, cleared only by rst
//   frame_cnt    frames started, wraps modulo 256
module matrix_scan_ctrl #(
    parameter int unsigned NUM_PIX     = 56,
    parameter int unsigned DWELL       = 1000,
    parameter int unsigned UPD_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       upd_req,
    input  logic       upd_done,
    output logic [5:0] sel,
    output logic       pix_valid,
    output logic       frame_start,
    output logic       upd_gnt,
    output logic       upd_err,
    output logic [7:0] frame_cnt
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned TO_W = (UPD_TIMEOUT > 1) ? $clog2(UPD_TIMEOUT) : 1;
    localparam logic [DW_W-1:0] DW_LAST  = DW_W'(DWELL - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(UPD_TIMEOUT - 1);
    localparam logic [5:0]      SEL_LAST = 6'(NUM_PIX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        UPDATE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [5:0]      sel_q, sel_d;
    logic            pix_valid_q, pix_valid_d;
    logic            frame_start_q, frame_start_d;
    logic            upd_gnt_q, upd_gnt_d;
    logic            upd_err_q, upd_err_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [TO_W-1:0] to_q, to_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            upd_gnt_q     <= 1'b0;
            upd_err_q     <= 1'b0;
            frame_cnt_q   <= '0;
            dwell_q       <= '0;
            to_q          <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            upd_gnt_q     <= upd_gnt_d;
            upd_err_q     <= upd_err_d;
            frame_cnt_q   <= frame_cnt_d;
            dwell_q       <= dwell_d;
            to_q          <= to_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        pix_valid_d   = pix_valid_q;
        frame_start_d = 1'b0;
        upd_gnt_d     = upd_gnt_q;
        upd_err_d     = upd_err_q;
        frame_cnt_d   = frame_cnt_q;
        dwell_d       = dwell_q;
        to_d          = to_q;

        case (state_q)
            IDLE: begin
                sel_d       = '0;
                pix_valid_d = 1'b0;
                if (upd_req) begin
                    state_d   = UPDATE;
                    upd_gnt_d = 1'b1;
                    to_d      = '0;
                end else if (en) begin
                    state_d       = SCAN;
                    dwell_d       = '0;
                    pix_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 8'd1;
                end
            end

            SCAN: begin
                if (dwell_q == DW_LAST) begin
                    dwell_d = '0;
                    if (!en) begin
                        state_d     = IDLE;
                        sel_d       = '0;
                        pix_valid_d = 1'b0;
                    end else if (sel_q != SEL_LAST) begin
                        sel_d = sel_q + 6'd1;
                    end else if (upd_req) begin
                        // Pending request is served only once the frame is complete
                        state_d     = UPDATE;
                        sel_d       = '0;
                        pix_valid_d = 1'b0;
                        upd_gnt_d   = 1'b1;
                        to_d        = '0;
                    end else begin
                        sel_d         = '0;
                        frame_start_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + 8'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end

            UPDATE: begin
                // Done wins over a coincident timeout, so no error in that case
                if (upd_done || (to_q == TO_LAST)) begin
                    upd_gnt_d = 1'b0;
                    to_d      = '0;
                    if (!upd_done) begin
                        upd_err_d = 1'b1;
                    end
                    if (en) begin
                        state_d       = SCAN;
                        sel_d         = '0;
                        dwell_d       = '0;
                        pix_valid_d   = 1'b1;
                        frame_start_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            default: begin
                state_d     = IDLE;
                sel_d       = '0;
                pix_valid_d = 1'b0;
                upd_gnt_d   = 1'b0;
            end
        endcase
    end

    assign sel         = sel_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;
    assign upd_gnt     = upd_gnt_q;
    assign upd_err     = upd_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Testbench for matrix_scan_ctrl (NUM_PIX=56, DWELL=4, UPD_TIMEOUT=16).
// Every cycle the expected outputs from a frame-position model are queued
// when inputs are driven and popped for comparison after the clock edge;
// directed constant checks mark the key points of each scenario.
module tb_matrix_scan_ctrl;

    localparam int unsigned NP  = 56;
    localparam int unsigned DW  = 4;
    localparam int unsigned UTO = 16;
    localparam int unsigned FRAME = NP * DW;

    logic       clk;
    logic       rst;
    logic       en;
    logic       upd_req;
    logic       upd_done;
    logic [5:0] sel;
    logic       pix_valid;
    logic       frame_start;
    logic       upd_gnt;
    logic       upd_err;
    logic [7:0] frame_cnt;

    matrix_scan_ctrl #(
        .NUM_PIX    (NP),
        .DWELL      (DW),
        .UPD_TIMEOUT(UTO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .upd_req    (upd_req),
        .upd_done   (upd_done),
        .sel        (sel),
        .pix_valid  (pix_valid),
        .frame_start(frame_start),
        .upd_gnt    (upd_gnt),
        .upd_err    (upd_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] sel;
        logic       pv;
        logic       fs;
        logic       gnt;
        logic       err;
        logic [7:0] fcnt;
    } obs_t;

    obs_t exp_q[$];
    int   vectors;
    int   miscompares;

    // Model: position within the frame rather than pixel/dwell counters
    typedef enum int {M_IDLE, M_SCAN, M_UPD} m_state_e;
    m_state_e   m_st;
    int         m_pos;
    int         m_gc;
    logic       m_fs;
    logic       m_err;
    logic [7:0] m_fc;
    logic       en_s;
    logic       req_s;

    function automatic int m_sel();
        return (m_st == M_SCAN) ? (m_pos / int'(DW)) : 0;
    endfunction

    task automatic m_start_frame();
        m_st  = M_SCAN;
        m_pos = 0;
        m_fs  = 1'b1;
        m_fc  = m_fc + 8'd1;
    endtask

    task automatic m_step(input logic r, input logic e, input logic q, input logic d);
        m_fs = 1'b0;
        if (r) begin
            m_st = M_IDLE; m_pos = 0; m_gc = 0; m_err = 1'b0; m_fc = 8'd0;
        end else begin
            case (m_st)
                M_IDLE: begin
                    if (q) begin m_st = M_UPD; m_gc = 1; end
                    else if (e) m_start_frame();
                end
                M_SCAN: begin
                    if ((m_pos % int'(DW)) == int'(DW) - 1) begin
                        if (!e) m_st = M_IDLE;
                        else if (m_pos == int'(FRAME) - 1) begin
                            if (q) begin m_st = M_UPD; m_gc = 1; end
                            else m_start_frame();
                        end else m_pos++;
                    end else m_pos++;
                end
                default: begin
                    if (d || m_gc == int'(UTO)) begin
                        if (!d) m_err = 1'b1;
                        if (e) m_start_frame();
                        else m_st = M_IDLE;
                    end else m_gc++;
                end
            endcase
        end
    endtask

    // One clock: drive inputs, queue the model's prediction, compare after the edge
    task automatic cyc(input logic r, input logic e, input logic q, input logic d, input string tag);
        obs_t ex, ob;
        rst = r; en = e; upd_req = q; upd_done = d;
        m_step(r, e, q, d);
        ex.sel  = 6'(m_sel());
        ex.pv   = (m_st == M_SCAN);
        ex.fs   = m_fs;
        ex.gnt  = (m_st == M_UPD);
        ex.err  = m_err;
        ex.fcnt = m_fc;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        ex = exp_q.pop_front();
        ob = '{sel: sel, pv: pix_valid, fs: frame_start, gnt: upd_gnt, err: upd_err, fcnt: frame_cnt};
        vectors++;
        assert (ob === ex) else begin
            miscompares++;
            $error("FAIL %s: observed sel=%0d pv=%b fs=%b gnt=%b err=%b fcnt=%0d, expected sel=%0d pv=%b fs=%b gnt=%b err=%b fcnt=%0d",
                   tag, ob.sel, ob.pv, ob.fs, ob.gnt, ob.err, ob.fcnt,
                   ex.sel, ex.pv, ex.fs, ex.gnt, ex.err, ex.fcnt);
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, en_s, req_s, 1'b0, tag);
    endtask

    // Directed check against a fixed expected value
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic bound_fail(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: target not reached within cycle budget", tag);
    endtask

    initial begin
        int k;
        clk = 1'b0; rst = 1'b1; en = 1'b0; upd_req = 1'b0; upd_done = 1'b0;
        vectors = 0; miscompares = 0;
        m_st = M_IDLE; m_pos = 0; m_gc = 0; m_fs = 1'b0; m_err = 1'b0; m_fc = 8'd0;
        en_s = 1'b0; req_s = 1'b0;

        // Reset: all outputs zero
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, "reset");
        chk("rst_sel", 8'(sel), 8'd0);
        chk("rst_pv", 8'(pix_valid), 8'd0);
        chk("rst_gnt", 8'(upd_gnt), 8'd0);
        chk("rst_fcnt", frame_cnt, 8'd0);
        run(2, "idle");

        // Enable: first pixel one clock after en
        en_s = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "en_rise");
        chk("en_fs", 8'(frame_start), 8'd1);
        chk("en_pv", 8'(pix_valid), 8'd1);
        chk("en_fcnt", frame_cnt, 8'd1);
        run(220, "scan1");
        chk("last_pix", 8'(sel), 8'd55);
        run(4, "scan1_end");
        chk("wrap_sel", 8'(sel), 8'd0);
        chk("wrap_fs", 8'(frame_start), 8'd1);
        chk("wrap_fcnt", frame_cnt, 8'd2);

        // Frame-boundary grant; done ignored outside UPDATE
        cyc(1'b0, 1'b1, 1'b0, 1'b1, "done_in_scan");
        k = 0;
        while (m_sel() != 10 && k < 400) begin run(1, "to_sel10"); k++; end
        if (k >= 400) bound_fail("wait_sel10");
        req_s = 1'b1;
        k = 0;
        while (m_st != M_UPD && k < 400) begin run(1, "pending_req"); k++; end
        if (k >= 400) bound_fail("wait_grant");
        chk("fb_gnt", 8'(upd_gnt), 8'd1);
        chk("fb_pv", 8'(pix_valid), 8'd0);
        en_s = 1'b0;
        run(4, "gnt_en_ignored");
        en_s = 1'b1;
        run(1, "gnt_hold");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, "fb_done");
        chk("fb_done_gnt", 8'(upd_gnt), 8'd0);
        chk("fb_done_fs", 8'(frame_start), 8'd1);
        chk("fb_done_fcnt", frame_cnt, 8'd3);

        // Request still high: a full frame runs before the next grant
        run(223, "full_frame");
        chk("no_early_gnt", 8'(upd_gnt), 8'd0);
        run(1, "regrant");
        chk("regrant", 8'(upd_gnt), 8'd1);
        en_s = 1'b0; req_s = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "done_to_idle");
        chk("idle_pv", 8'(pix_valid), 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "done_in_idle");

        // Idle grant; done coinciding with timeout is a normal done
        req_s = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "idle_grant");
        chk("idle_gnt", 8'(upd_gnt), 8'd1);
        req_s = 1'b0;
        run(15, "to_edge");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "done_at_timeout");
        chk("tie_err", 8'(upd_err), 8'd0);
        chk("tie_gnt", 8'(upd_gnt), 8'd0);

        // Idle grant with early done back to IDLE
        req_s = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "idle_grant2");
        req_s = 1'b0;
        run(2, "gnt2_hold");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "gnt2_done");
        chk("gnt2_pv", 8'(pix_valid), 8'd0);

        // Timeout: grant held 16 clocks, then sticky error
        en_s = 1'b1; req_s = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, "req_prio");
        chk("prio_gnt", 8'(upd_gnt), 8'd1);
        req_s = 1'b0;
        run(15, "timeout_wait");
        chk("to_gnt_held", 8'(upd_gnt), 8'd1);
        chk("to_err_clear", 8'(upd_err), 8'd0);
        run(1, "timeout");
        chk("to_gnt", 8'(upd_gnt), 8'd0);
        chk("to_err", 8'(upd_err), 8'd1);
        chk("to_fs", 8'(frame_start), 8'd1);
        run(230, "err_sticky");
        chk("err_sticky", 8'(upd_err), 8'd1);

        // Disable mid-frame at sel=20, dwell=1
        k = 0;
        while (!(m_st == M_SCAN && m_sel() == 20 && (m_pos % int'(DW)) == 1) && k < 400) begin
            run(1, "to_sel20");
            k++;
        end
        if (k >= 400) bound_fail("wait_sel20");
        en_s = 1'b0;
        run(2, "dis_hold");
        chk("dis_sel_held", 8'(sel), 8'd20);
        run(1, "dis_idle");
        chk("dis_pv", 8'(pix_valid), 8'd0);
        chk("dis_fs", 8'(frame_start), 8'd0);

        // Reset mid-grant
        req_s = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "grant_pre_rst");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, "rst_mid_grant");
        chk("rstg_gnt", 8'(upd_gnt), 8'd0);
        chk("rstg_fcnt", frame_cnt, 8'd0);
        chk("rstg_err", 8'(upd_err), 8'd0);
        req_s = 1'b0;
        run(1, "post_rst");

        // frame_cnt wraps 255 -> 0
        en_s = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "wrap_start");
        chk("wrap_f1", frame_cnt, 8'd1);
        run(254 * FRAME, "wrap_run");
        chk("wrap_255", frame_cnt, 8'd255);
        run(FRAME, "wrap_run2");
        chk("wrap_0", frame_cnt, 8'd0);
        chk("wrap_0_fs", 8'(frame_start), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
